// File: rtl/irq_pending_ctrl_if.sv
// rtl/irq_pending_ctrl_if.sv - request/handshake bundle for irq_pending_ctrl (mask present when IRQ_MASK_EN is defined)
interface irq_pending_ctrl_if;
    logic [3:0] req;
    logic       ack;
`ifdef IRQ_MASK_EN
    logic [3:0] mask;
`endif
    logic [3:0] pend;
    logic [1:0] idx;
    logic       valid;

    modport slave (
        input  req,
        input  ack,
`ifdef IRQ_MASK_EN
        input  mask,
`endif
        output pend,
        output idx,
        output valid
    );

    modport master (
        output req,
        output ack,
`ifdef IRQ_MASK_EN
        output mask,
`endif
        input  pend,
        input  idx,
        input  valid
    );
endinterface

// File: rtl/irq_pending_ctrl.sv
// rtl/irq_pending_ctrl.sv - sync, sticky pending capture and fixed-priority locked grant (optional IRQ_MASK_EN)
module irq_pending_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    irq_pending_ctrl_if.slave    irq
);
    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t     r_state;
    logic [3:0] r_sync [SYNC_STAGES];
    logic [3:0] r_prev;
    logic [3:0] r_pend;
    logic [1:0] r_idx;
    logic       r_valid;

    logic [3:0] w_sync_out;
    logic [3:0] w_set;
    logic [3:0] w_clr;
    logic [3:0] w_elig;
    logic [1:0] w_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= irq.req;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_prev <= w_sync_out;
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    generate
        if (EDGE_MODE == 1) begin : g_edge
            assign w_set = w_sync_out & ~r_prev;
        end else begin : g_level
            assign w_set = w_sync_out;
        end
    endgenerate

    always_comb begin
        w_clr = '0;
        if (r_valid && irq.ack) w_clr[r_idx] = 1'b1;
    end

    // Set is OR-ed in after the clear so a coincident new request survives the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pend <= '0;
        else        r_pend <= w_set | (r_pend & ~w_clr);
    end

`ifdef IRQ_MASK_EN
    assign w_elig = r_pend & ~irq.mask;
`else
    assign w_elig = r_pend;
`endif

    always_comb begin
        w_hi = '0;
        for (int i = 0; i < 4; i++) if (w_elig[i]) w_hi = 2'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_idx   <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_elig) begin
                        r_idx   <= w_hi;
                        r_valid <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (irq.ack) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign irq.pend  = r_pend;
    assign irq.idx   = r_idx;
    assign irq.valid = r_valid;
endmodule
